// File: rtl/rice_stream_decoder.sv
// Streaming Rice (Golomb power-of-two) decoder: unpacks MSB-first compressed words
// into symbols (q << k) | r through a 2*IN_W bit buffer.
module rice_stream_decoder #(
  parameter int IN_W  = 16,
  parameter int SYM_W = 16,
  parameter int KW    = 5,
  parameter int MAXQ  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [KW-1:0]    k,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SYM_W-1:0] sym_data,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic             busy,
  output logic             err,
  output logic [15:0]      sym_count
);

  localparam int BUF_W  = 2 * IN_W;
  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam int Q_W    = $clog2(MAXQ + 2);
  localparam logic [FILL_W-1:0] IN_W_F = FILL_W'(IN_W);
  localparam logic [Q_W-1:0]    MAXQ_Q = Q_W'(MAXQ);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_UNARY = 3'd1,
    S_REM   = 3'd2,
    S_OUT   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [Q_W-1:0]    q_q, q_d;
  logic [SYM_W-1:0]  r_q, r_d;
  logic [KW-1:0]     k_q, k_d;
  logic [KW-1:0]     rcnt_q, rcnt_d;
  logic [SYM_W-1:0]  sym_q, sym_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              stop_pend_q, stop_pend_d;
  logic              err_q, err_d;

  logic              consume;
  logic              discard;
  logic              accept;
  logic              have_bit;
  logic              head_bit;
  logic              fill_ok;
  logic [SYM_W-1:0]  r_shift;
  logic [SYM_W-1:0]  q_ext;
  logic [BUF_W-1:0]  shifted;
  logic [BUF_W-1:0]  incoming;
  logic [FILL_W-1:0] fill_c;

  assign have_bit = (fill_q != '0);
  assign head_bit = buf_q[BUF_W-1];
  assign fill_ok  = (fill_q <= IN_W_F);
  assign accept   = in_valid & in_ready;
  assign r_shift  = {r_q[SYM_W-2:0], head_bit};
  assign q_ext    = SYM_W'(q_q);

  // Bit buffer: valid bits are kept MSB-aligned, new words land just below them.
  always_comb begin
    shifted  = consume ? {buf_q[BUF_W-2:0], 1'b0} : buf_q;
    fill_c   = fill_q - FILL_W'(consume);
    incoming = {in_data, {IN_W{1'b0}}} >> fill_c;
    buf_d    = shifted;
    fill_d   = fill_c;
    if (discard) begin
      buf_d  = '0;
      fill_d = '0;
    end else if (accept) begin
      buf_d  = shifted | incoming;
      fill_d = fill_c + IN_W_F;
    end else begin
      buf_d  = shifted;
      fill_d = fill_c;
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      fill_q      <= '0;
      q_q         <= '0;
      r_q         <= '0;
      k_q         <= '0;
      rcnt_q      <= '0;
      sym_q       <= '0;
      cnt_q       <= 16'd0;
      stop_pend_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      q_q         <= q_d;
      r_q         <= r_d;
      k_q         <= k_d;
      rcnt_q      <= rcnt_d;
      sym_q       <= sym_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
      err_q       <= err_d;
    end
  end

  // Next-state and decode datapath.
  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    r_d         = r_q;
    k_d         = k_q;
    rcnt_d      = rcnt_q;
    sym_d       = sym_q;
    cnt_d       = cnt_q;
    stop_pend_d = stop_pend_q;
    err_d       = err_q;
    consume     = 1'b0;
    discard     = 1'b0;
    if (state_q != S_IDLE && stop) begin
      stop_pend_d = 1'b1;
    end else begin
      stop_pend_d = stop_pend_q;
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d         = k;
          q_d         = '0;
          r_d         = '0;
          rcnt_d      = '0;
          cnt_d       = 16'd0;
          stop_pend_d = 1'b0;
          if (32'(k) >= 32'(SYM_W)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_UNARY;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_UNARY: begin
        if (have_bit) begin
          consume = 1'b1;
          if (!head_bit) begin
            // A zero beyond MAXQ means a corrupt or misaligned stream.
            if (q_q == MAXQ_Q) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end else begin
              q_d = q_q + Q_W'(1);
            end
          end else if (k_q == '0) begin
            state_d = S_OUT;
            sym_d   = q_ext;
          end else begin
            state_d = S_REM;
            rcnt_d  = '0;
          end
        end else begin
          state_d = S_UNARY;
        end
      end
      S_REM: begin
        if (have_bit) begin
          consume = 1'b1;
          r_d     = r_shift;
          if (rcnt_q == k_q - KW'(1)) begin
            state_d = S_OUT;
            sym_d   = (q_ext << k_q) | r_shift;
          end else begin
            rcnt_d = rcnt_q + KW'(1);
          end
        end else begin
          state_d = S_REM;
        end
      end
      S_OUT: begin
        if (sym_ready) begin
          cnt_d = cnt_q + 16'd1;
          q_d   = '0;
          r_d   = '0;
          if (stop_pend_q || stop) begin
            state_d     = S_IDLE;
            discard     = 1'b1;
            stop_pend_d = 1'b0;
          end else begin
            state_d = S_UNARY;
          end
        end else begin
          state_d = S_OUT;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
        err_d   = 1'b1;
      end
      default: begin
        state_d = S_ERR;
        err_d   = 1'b1;
      end
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    in_ready  = 1'b0;
    sym_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_UNARY, S_REM: begin
        in_ready = fill_ok;
      end
      S_OUT: begin
        in_ready  = fill_ok;
        sym_valid = 1'b1;
      end
      S_ERR: begin
        in_ready = 1'b0;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign sym_data  = sym_q;
  assign sym_count = cnt_q;
  assign err       = err_q;

endmodule

// File: doc/rice_stream_decoder.md
RICE_STREAM_DECODER -- requirements
Module: rice_stream_decoder

Interface
REQ-001 SHALL have parameter IN_W, default 16: width of each compressed input word, consumed MSB first.
REQ-002 SHALL have parameter SYM_W, default 16: width of each decoded symbol.
REQ-003 SHALL have parameter KW, default 5: width of the Rice parameter k.
REQ-004 SHALL have parameter MAXQ, default 32: largest legal unary quotient.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic rises on it.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: begin decoding; k is captured when start is accepted.
REQ-008 SHALL have port stop, input, 1: request a flush at the next symbol boundary.
REQ-009 SHALL have port k, input, KW: the Rice parameter.
REQ-010 SHALL have ports in_data (input, IN_W), in_valid (input, 1) and in_ready (output, 1): the compressed-word handshake.
REQ-011 SHALL have ports sym_data (output, SYM_W), sym_valid (output, 1) and sym_ready (input, 1): the symbol handshake.
REQ-012 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-013 SHALL have port err, output, 1: sticky error flag.
REQ-014 SHALL have port sym_count, output, 16: number of symbols delivered since start, wrapping at 2^16.

Function
REQ-015 SHALL hold a bit buffer of 2*IN_W bits with a fill count; in_ready = (fill <= IN_W) and state is neither ERR nor IDLE.
REQ-016 SHALL append an accepted word (in_valid & in_ready) directly below the existing valid bits; an accept and a one-bit consume in the same cycle SHALL both take effect (fill += IN_W-1).
REQ-017 SHALL implement the states IDLE, UNARY, REM, OUT and ERR.
REQ-018 IDLE: on start, SHALL capture k, clear q, r and sym_count, and move to UNARY next cycle; start is ignored in every other state.
REQ-019 UNARY: each cycle with fill>0, SHALL consume one bit; a '0' increments q; a '1' moves to REM, or to OUT when captured k=0.
REQ-020 UNARY: if q would reach MAXQ+1, SHALL move to ERR.
REQ-021 REM: each cycle with fill>0, SHALL shift one bit into r; after k bits, SHALL move to OUT.
REQ-022 Stall: when fill=0 in UNARY or REM, SHALL hold state, q and r.
REQ-023 OUT: sym_data = ((q << k) | r) truncated to SYM_W; sym_valid=1; sym_data SHALL be stable while sym_ready=0.
REQ-024 OUT, on sym_ready: SHALL increment sym_count, clear q and r, and go to UNARY, or to IDLE if stop is pending.
REQ-025 SHALL latch stop as pending in any busy state; reaching IDLE via stop SHALL discard the buffer (fill=0) and clear the pending flag.
REQ-026 SHALL treat captured k >= SYM_W as a configuration error: ERR on the cycle after start.
REQ-027 ERR: SHALL set err=1, hold in_ready=0 and sym_valid=0, and leave only on reset.
REQ-028 Minimum latency SHALL be q+1+k+1 cycles from the first bit of a code to sym_valid, given data available and no backpressure.

Reset
REQ-029 On reset, SHALL set state=IDLE, fill=0, q=0, r=0, sym_count=0, err=0, sym_valid=0, in_ready=0, busy=0, sym_data=0, and clear pending stop.
REQ-030 Reset SHALL take priority over all other inputs, including during mid-symbol decoding and in ERR.

Verification
REQ-031 k=3, start, in_data=16'h1B4F, sym_ready=1 -> symbols 29, 2, 15 in order; sym_count=3.
REQ-032 k=0, in_data=16'hA000 -> symbols 0, then 1; decoder then stalls in UNARY with q=13 and busy=1.
REQ-033 k=3, three words of 16'h0000 -> err=1 after the 33rd zero; in_ready=0; sym_valid never asserted.
REQ-034 k=3, 16'h1B4F with sym_ready=0 for 10 cycles -> sym_data=29 held stable; in_ready=1 while fill <= 16, then 0 once two further words are buffered.
REQ-035 stop asserted mid-decode of the second symbol -> symbol 2 is still delivered, then IDLE with fill=0 and busy=0; a subsequent start decodes cleanly.
REQ-036 reset asserted during REM -> on the next cycle all outputs match REQ-029; k=20 with start -> err=1 two cycles later.
